// File: rtl/muldiv_unit.sv
// muldiv_unit: multicycle shift-add multiply / restoring divide producing HI/LO; MULDIV_ZERO_SKIP_EN enables zero-operand early completion
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0] opr;
  logic sa, sb, dz, zs;
  logic [WIDTH-1:0] ma, mb, d, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] pr, pr_n, prod;
  logic [WIDTH:0] sum, trial, diff;
  assign busy = state != IDLE;
  assign dz = op[1] && b == '0;
`ifdef MULDIV_ZERO_SKIP_EN
  assign zs = !dz && (a == '0 || (!op[1] && b == '0));
`else
  assign zs = 1'b0;
`endif
  always_comb begin
    ma = !op[0] && a[WIDTH-1] ? -a : a;
    mb = !op[0] && b[WIDTH-1] ? -b : b;
    sum = {1'b0, pr[2*WIDTH-1:WIDTH]} + {1'b0, pr[0] ? d : '0};
    trial = pr[2*WIDTH-1:WIDTH-1];
    diff = trial - {1'b0, d};
    pr_n = opr[1] ? (diff[WIDTH] ? {trial[WIDTH-1:0], pr[WIDTH-2:0], 1'b0}
                                 : {diff[WIDTH-1:0], pr[WIDTH-2:0], 1'b1})
                  : {sum, pr[WIDTH-1:1]};
    prod = sa ^ sb ? -pr : pr;
    fix_hi = opr[1] ? (sa ? -pr[2*WIDTH-1:WIDTH] : pr[2*WIDTH-1:WIDTH]) : prod[2*WIDTH-1:WIDTH];
    fix_lo = opr[1] ? (sa ^ sb ? -pr[WIDTH-1:0] : pr[WIDTH-1:0]) : prod[WIDTH-1:0];
  end
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start && !dz && !zs ? RUN : IDLE)
            : state == RUN  ? (cnt == LAST ? FIX : RUN)
            : IDLE;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  // Multiply keeps the multiplicand in d and the multiplier in pr's low half;
  // divide keeps the divisor in d and the dividend in pr's low half.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      opr <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      d <= '0;
      pr <= '0;
      done <= 1'b0;
      div0 <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      case (state)
        IDLE: if (start) begin
          opr <= op;
          sa <= !op[0] && a[WIDTH-1];
          sb <= !op[0] && b[WIDTH-1];
          d <= op[1] ? mb : ma;
          pr <= {{WIDTH{1'b0}}, op[1] ? ma : mb};
          cnt <= '0;
          if (dz) begin
            done <= 1'b1;
            div0 <= 1'b1;
          end else if (zs) begin
            done <= 1'b1;
            hi <= '0;
            lo <= '0;
          end
        end
        RUN: begin
          pr <= pr_n;
          cnt <= cnt + 1'b1;
        end
        default: begin
          hi <= fix_hi;
          lo <= fix_lo;
          done <= 1'b1;
        end
      endcase
    end
  end
endmodule
